// File: rtl/reg_bank_demux16.sv
// rtl/reg_bank_demux16.sv - write-side 1:16 demux into sixteen holding registers
//
// Steers words from the shared input bus into one of sixteen WIDTH-bit
// registers (outR0..outR15) under a valid/ready handshake. Transfers are
// single-word or auto-incrementing bursts. clr synchronously zeroes the bank.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   inBus      in   write data
//   se1        in   destination index, sampled on the first beat
//   wr_valid   in   write beat offered
//   wr_ready   out  beat can be accepted (~clr)
//   burst      in   first beat: 1 selects an auto-increment burst
//   burst_len  in   first beat: burst beats minus 1
//   clr        in   synchronous clear of the bank, aborts any burst
//   outR0..15  out  register contents
//   busy       out  burst in progress
//   done       out  one-cycle pulse after the final beat of a transfer
module reg_bank_demux16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inBus,
    input  logic [3:0]       se1,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             burst,
    input  logic [3:0]       burst_len,
    input  logic             clr,
    output logic [WIDTH-1:0] outR0,
    output logic [WIDTH-1:0] outR1,
    output logic [WIDTH-1:0] outR2,
    output logic [WIDTH-1:0] outR3,
    output logic [WIDTH-1:0] outR4,
    output logic [WIDTH-1:0] outR5,
    output logic [WIDTH-1:0] outR6,
    output logic [WIDTH-1:0] outR7,
    output logic [WIDTH-1:0] outR8,
    output logic [WIDTH-1:0] outR9,
    output logic [WIDTH-1:0] outR10,
    output logic [WIDTH-1:0] outR11,
    output logic [WIDTH-1:0] outR12,
    output logic [WIDTH-1:0] outR13,
    output logic [WIDTH-1:0] outR14,
    output logic [WIDTH-1:0] outR15,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_nxt_state;
    logic [3:0]       r_ptr;
    logic [3:0]       w_nxt_ptr;
    logic [3:0]       r_rem;
    logic [3:0]       w_nxt_rem;
    logic             r_busy;
    logic             w_nxt_busy;
    logic             r_done;
    logic             w_nxt_done;
    logic             w_we;
    logic [3:0]       w_waddr;
    logic [WIDTH-1:0] r_bank [16];

    // clr blocks acceptance in the same cycle, so a beat offered with clr is
    // simply not taken rather than being written and then wiped.
    assign wr_ready = ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 4'd0;
            r_rem   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_rem   <= w_nxt_rem;
            r_busy  <= w_nxt_busy;
            r_done  <= w_nxt_done;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_rem   = r_rem;
        w_nxt_busy  = r_busy;
        w_nxt_done  = 1'b0;
        w_we        = 1'b0;
        w_waddr     = r_ptr;
        if (clr) begin
            w_nxt_state = S_IDLE;
            w_nxt_ptr   = 4'd0;
            w_nxt_rem   = 4'd0;
            w_nxt_busy  = 1'b0;
        end else if (wr_valid) begin
            w_we = 1'b1;
            case (r_state)
                S_IDLE: begin
                    w_waddr = se1;
                    if (!burst || burst_len == 4'd0) begin
                        w_nxt_done = 1'b1;
                    end else begin
                        // Pointer wraps mod 16 so a 16-beat burst covers every register once.
                        w_nxt_ptr   = se1 + 4'd1;
                        w_nxt_rem   = burst_len - 4'd1;
                        w_nxt_state = S_BURST;
                        w_nxt_busy  = 1'b1;
                    end
                end
                S_BURST: begin
                    w_waddr   = r_ptr;
                    w_nxt_ptr = r_ptr + 4'd1;
                    if (r_rem == 4'd0) begin
                        w_nxt_state = S_IDLE;
                        w_nxt_busy  = 1'b0;
                        w_nxt_done  = 1'b1;
                    end else begin
                        w_nxt_rem = r_rem - 4'd1;
                    end
                end
                default: begin
                    w_nxt_state = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_bank[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < 16; i++) r_bank[i] <= '0;
        end else if (w_we) begin
            r_bank[w_waddr] <= inBus;
        end
    end

    assign outR0  = r_bank[0];
    assign outR1  = r_bank[1];
    assign outR2  = r_bank[2];
    assign outR3  = r_bank[3];
    assign outR4  = r_bank[4];
    assign outR5  = r_bank[5];
    assign outR6  = r_bank[6];
    assign outR7  = r_bank[7];
    assign outR8  = r_bank[8];
    assign outR9  = r_bank[9];
    assign outR10 = r_bank[10];
    assign outR11 = r_bank[11];
    assign outR12 = r_bank[12];
    assign outR13 = r_bank[13];
    assign outR14 = r_bank[14];
    assign outR15 = r_bank[15];
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_reg_bank_demux16.sv
// tb/tb_reg_bank_demux16.sv - directed self-checking bench for reg_bank_demux16
module tb_reg_bank_demux16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] inBus;
    logic [3:0]  se1;
    logic        wr_valid;
    logic        wr_ready;
    logic        burst;
    logic [3:0]  burst_len;
    logic        clr;
    logic        busy;
    logic        done;
    logic [15:0] w_out [16];
    logic [15:0] exp_bank [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_bank_demux16 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .inBus(inBus), .se1(se1),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .burst(burst),
        .burst_len(burst_len), .clr(clr),
        .outR0(w_out[0]),   .outR1(w_out[1]),   .outR2(w_out[2]),   .outR3(w_out[3]),
        .outR4(w_out[4]),   .outR5(w_out[5]),   .outR6(w_out[6]),   .outR7(w_out[7]),
        .outR8(w_out[8]),   .outR9(w_out[9]),   .outR10(w_out[10]), .outR11(w_out[11]),
        .outR12(w_out[12]), .outR13(w_out[13]), .outR14(w_out[14]), .outR15(w_out[15]),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bank(input string tag);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_R%0d", tag, i), w_out[i], exp_bank[i]);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 16; i++) exp_bank[i] = 16'h0000;
    endtask

    task automatic flags(input string tag, input logic b, input logic d);
        chk({tag, "_busy"}, {15'd0, busy}, {15'd0, b});
        chk({tag, "_done"}, {15'd0, done}, {15'd0, d});
    endtask

    initial begin
        rst_n = 1'b0; inBus = '0; se1 = '0; wr_valid = 1'b0;
        burst = 1'b0; burst_len = '0; clr = 1'b0;
        clear_exp();
        step(); step();
        rst_n = 1'b1;
        step();

        // Preload R5, then reset and confirm it is cleared.
        se1 = 4'd5; inBus = 16'h1234; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        chk("pre_R5", w_out[5], 16'h1234);
        rst_n = 1'b0;
        #1;
        chk_bank("reset");
        flags("reset", 1'b0, 1'b0);
        chk("reset_wr_ready", {15'd0, wr_ready}, 16'd1);
        step();
        rst_n = 1'b1;
        step();

        // Single write.
        se1 = 4'd5; inBus = 16'hA5A5; burst = 1'b0; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        exp_bank[5] = 16'hA5A5;
        chk_bank("single");
        flags("single", 1'b0, 1'b1);
        step();
        flags("single_after", 1'b0, 1'b0);

        // Wrapping burst E,F,0,1.
        se1 = 4'hE; burst = 1'b1; burst_len = 4'd3; inBus = 16'h1111; wr_valid = 1'b1;
        step();
        flags("wrap_b1", 1'b1, 1'b0);
        se1 = 4'd3; burst = 1'b0; burst_len = 4'd0;
        inBus = 16'h2222; step(); flags("wrap_b2", 1'b1, 1'b0);
        inBus = 16'h3333; step(); flags("wrap_b3", 1'b1, 1'b0);
        inBus = 16'h4444; step(); flags("wrap_b4", 1'b0, 1'b1);
        wr_valid = 1'b0;
        step();
        flags("wrap_after", 1'b0, 1'b0);
        exp_bank[14] = 16'h1111; exp_bank[15] = 16'h2222;
        exp_bank[0]  = 16'h3333; exp_bank[1]  = 16'h4444;
        chk_bank("wrap");

        // Full-bank burst with a 2-cycle gap after beat 7.
        for (int n = 0; n < 16; n++) begin
            if (n == 0) begin
                se1 = 4'd0; burst = 1'b1; burst_len = 4'd15;
            end else begin
                se1 = 4'd9; burst = 1'b0; burst_len = 4'd0;
            end
            inBus = 16'(n * 16'h0101); wr_valid = 1'b1;
            step();
            exp_bank[n] = 16'(n * 16'h0101);
            if (n == 6) begin
                wr_valid = 1'b0; inBus = 16'hDEAD;
                step(); flags("gap1", 1'b1, 1'b0);
                step(); flags("gap2", 1'b1, 1'b0);
                chk("gap_R7", w_out[7], 16'h3333 & 16'h0000);
            end
        end
        wr_valid = 1'b0;
        flags("full_end", 1'b0, 1'b1);
        chk_bank("full");
        step();

        // clr mid-burst on beat 4.
        se1 = 4'd2; burst = 1'b1; burst_len = 4'd7; inBus = 16'h0A01; wr_valid = 1'b1;
        step();
        inBus = 16'h0A02; step();
        inBus = 16'h0A03; step();
        inBus = 16'h0A04; clr = 1'b1;
        #1;
        chk("clr_wr_ready", {15'd0, wr_ready}, 16'd0);
        step();
        clr = 1'b0; wr_valid = 1'b0;
        clear_exp();
        chk_bank("clr");
        flags("clr", 1'b0, 1'b0);
        step();
        flags("clr_after", 1'b0, 1'b0);
        se1 = 4'd3; burst = 1'b0; inBus = 16'h0F0F; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        exp_bank[3] = 16'h0F0F;
        chk_bank("post_clr");
        flags("post_clr", 1'b0, 1'b1);
        step();

        // Back-to-back: single to R7, then burst of 2 at R9 during done.
        se1 = 4'd7; burst = 1'b0; inBus = 16'hBEEF; wr_valid = 1'b1;
        step();
        flags("b2b_single", 1'b0, 1'b1);
        se1 = 4'd9; burst = 1'b1; burst_len = 4'd1; inBus = 16'h0001;
        step();
        flags("b2b_b1", 1'b1, 1'b0);
        inBus = 16'h0002; burst = 1'b0;
        step();
        flags("b2b_b2", 1'b0, 1'b1);
        wr_valid = 1'b0;
        step();
        flags("b2b_after", 1'b0, 1'b0);
        exp_bank[7] = 16'hBEEF; exp_bank[9] = 16'h0001; exp_bank[10] = 16'h0002;
        chk_bank("b2b");

        // Async reset during beat 2 of a 4-beat burst.
        se1 = 4'd4; burst = 1'b1; burst_len = 4'd3; inBus = 16'h1000; wr_valid = 1'b1;
        step();
        flags("ar_b1", 1'b1, 1'b0);
        inBus = 16'h2000; burst = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        clear_exp();
        chk_bank("async_rst");
        flags("async_rst", 1'b0, 1'b0);
        wr_valid = 1'b0;
        step();
        flags("async_rst_hold", 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        flags("async_rst_rel", 1'b0, 1'b0);
        se1 = 4'd4; burst = 1'b0; inBus = 16'h5555; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        exp_bank[4] = 16'h5555;
        chk_bank("after_ar");
        flags("after_ar", 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
